// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the single register-file write port, with registered
// write port and saturating conflict counter. Define REGFILE_ARB_RR_EN for round-robin.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [CNT_W-1:0]  conflict_count
);

  typedef enum logic [1:0] {IDLE, WR_A, WR_B} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_wreg;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_conflict;
  logic                w_prio_b;

  assign w_conflict = a_valid && b_valid && !hold;

`ifdef REGFILE_ARB_RR_EN
  logic r_prio_b;

  // Every conflict grant goes to the pointer side, so flipping hands the next one to the loser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_prio_b <= 1'b0;
    else if (w_conflict) r_prio_b <= ~r_prio_b;
  end

  assign w_prio_b = r_prio_b;
`else
  assign w_prio_b = 1'b0;
`endif

  always_comb begin
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    w_state_nxt = IDLE;
    if (!hold) begin
      a_ready = a_valid && (!b_valid || !w_prio_b);
      b_ready = b_valid && (!a_valid ||  w_prio_b);
    end
    if (a_ready)      w_state_nxt = WR_A;
    else if (b_ready) w_state_nxt = WR_B;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (w_state_nxt)
        WR_A: begin
          r_wreg  <= a_reg;
          r_wdata <= a_data;
        end
        WR_B: begin
          r_wreg  <= b_reg;
          r_wdata <= b_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          r_cnt <= '0;
    else if (w_conflict && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Register 0 is hardwired: the request is consumed but never enables the write.
  assign RegWrite       = (r_state != IDLE) && (r_wreg != '0);
  assign write_reg      = r_wreg;
  assign write_data     = r_wdata;
  assign conflict_count = r_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus queues expected write-port
// contents, a negedge monitor pops and compares. A CNT_W=4 copy checks saturation.
module tb_regfile_write_arbiter;

`ifdef REGFILE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, hold, a_valid, b_valid;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [15:0] conflict_count;
  logic        a_ready4, b_ready4, RegWrite4;
  logic [4:0]  write_reg4;
  logic [31:0] write_data4;
  logic [3:0]  conflict_count4;

  int n_tests = 0;
  int n_fail  = 0;
  wr_t q[$];
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;
  int   exp_cnt, exp_cnt4;
  bit   pend;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .conflict_count(conflict_count)
  );

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .hold(hold),
    .a_valid(a_valid), .a_ready(a_ready4), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready4), .b_reg(b_reg), .b_data(b_data),
    .RegWrite(RegWrite4), .write_reg(write_reg4), .write_data(write_data4),
    .conflict_count(conflict_count4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("RegWrite",   64'(RegWrite),   64'(e.we));
      chk("write_reg",  64'(write_reg),  64'(e.r));
      chk("write_data", 64'(write_data), 64'(e.d));
    end
  end

  task automatic apply(input logic h, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       input logic ea, input logic eb);
    if (pend) begin
      exp_cnt++;
      if (exp_cnt4 != 15) exp_cnt4++;
    end
    hold = h; a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    #1;
    chk("a_ready", 64'(a_ready), 64'(ea));
    chk("b_ready", 64'(b_ready), 64'(eb));
    if (ea) begin
      exp_reg = ar; exp_data = ad;
      q.push_back('{ar != 5'd0, ar, ad});
    end else if (eb) begin
      exp_reg = br; exp_data = bd;
      q.push_back('{br != 5'd0, br, bd});
    end else begin
      q.push_back('{1'b0, exp_reg, exp_data});
    end
    pend = av && bv && !h;
  endtask

  task automatic drive(input logic h, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       input logic ea, input logic eb);
    @(negedge clk);
    #1;
    apply(h, av, ar, ad, bv, br, bd, ea, eb);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic check_cnt();
    chk("conflict_count",   64'(conflict_count),  64'(exp_cnt));
    chk("conflict_count_4", 64'(conflict_count4), 64'(exp_cnt4));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [4:0]  a_reg_n;
    logic [31:0] a_data_n;
    bit          ptr;
    reset = 1'b1; hold = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    exp_reg = '0; exp_data = '0; exp_cnt = 0; exp_cnt4 = 0; pend = 1'b0;
    #12;
    chk("rst RegWrite",   64'(RegWrite),   64'd0);
    chk("rst write_reg",  64'(write_reg),  64'd0);
    chk("rst write_data", 64'(write_data), 64'd0);
    check_cnt();
    @(negedge clk); #1 reset = 1'b0;

    // single A write
    drive(1'b0, 1'b1, 5'd3, 32'habcdef12, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    idle();

    // conflict A4/B5, then same-destination conflict on reg 6
    drive(1'b0, 1'b1, 5'd4, 32'h11, 1'b1, 5'd5, 32'h22, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'h22, 1'b0, 1'b1);
    idle();
    check_cnt();
    drive(1'b0, 1'b1, 5'd6, 32'h33, 1'b1, 5'd6, 32'h44, !RR, RR);
    if (RR) drive(1'b0, 1'b1, 5'd6, 32'h33, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    else    drive(1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'h44, 1'b0, 1'b1);
    idle();

    // write to register 0
    drive(1'b0, 1'b1, 5'd0, 32'hffffffff, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    idle();

    // hold with both valid
    for (int unsigned i = 0; i < 3; i++)
      drive(1'b1, 1'b1, 5'd10, 32'haa, 1'b1, 5'd11, 32'hbb, 1'b0, 1'b0);
    check_cnt();
    drive(1'b0, 1'b1, 5'd10, 32'haa, 1'b1, 5'd11, 32'hbb, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 5'd0,  32'h0,  1'b1, 5'd11, 32'hbb, 1'b0, 1'b1);
    idle();
    check_cnt();

    // reset mid-cycle while RegWrite=1; pending requests stay valid
    drive(1'b0, 1'b1, 5'd12, 32'hc1, 1'b1, 5'd13, 32'hc2, !RR, RR);
    @(negedge clk);
    a_reg_n  = RR ? 5'd12 : 5'd14;
    a_data_n = RR ? 32'hc1 : 32'hd1;
    #1 a_reg = a_reg_n; a_data = a_data_n;
    #1 reset = 1'b1;
    #1;
    chk("async RegWrite",   64'(RegWrite),   64'd0);
    chk("async write_reg",  64'(write_reg),  64'd0);
    chk("async write_data", 64'(write_data), 64'd0);
    exp_reg = '0; exp_data = '0; exp_cnt = 0; exp_cnt4 = 0; pend = 1'b0;
    check_cnt();
    @(negedge clk); #1 reset = 1'b0;
    apply(1'b0, 1'b1, a_reg_n, a_data_n, 1'b1, 5'd13, 32'hc2, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hc2, 1'b0, 1'b1);

    // continuous conflicts: CNT_W=4 copy saturates
    ptr = RR;
    for (int unsigned i = 0; i < 21; i++) begin
      drive(1'b0, 1'b1, 5'd15, 32'ha5a5, 1'b1, 5'd16, 32'h5a5a, !ptr, ptr);
      ptr = RR ? !ptr : ptr;
      if (i == 13) check_cnt();
    end
    idle();
    check_cnt();
    idle();
    @(negedge clk);
    #1 chk("scoreboard drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
